// File: rtl/div_issue_ctrl.sv
// Issue/complete controller for a multi-cycle divider: accepts one request, starts the divider,
// waits for its result (with stale-ready masking and a timeout), then holds the result until taken.
module div_issue_ctrl #(
  parameter int unsigned Timeout = 40,
  parameter int unsigned MinLat  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_op_a_i,
  input  logic [31:0] in_op_b_i,
  input  logic [4:0]  in_tag_i,

  output logic [31:0] div_op_a_o,
  output logic [31:0] div_op_b_o,
  output logic        div_start_o,
  input  logic [31:0] div_result_i,
  input  logic        div_exception_i,
  input  logic        div_result_rdy_i,

  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_result_o,
  output logic        out_exception_o,
  output logic [4:0]  out_tag_o,

  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);
  localparam logic [CntW-1:0] MinLatC      = CntW'(MinLat);
  localparam logic [CntW-1:0] TimeoutLastC = CntW'(Timeout - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       op_a_q, op_b_q, result_q;
  logic              exc_q;
  logic [4:0]        tag_q;
  logic              start_q, valid_q, busy_q, in_ready_q;
  logic              rdy_honoured;

  // A ready seen in the first MinLat WAIT cycles may be left over from the previous operation.
  assign rdy_honoured = div_result_rdy_i && (cnt_q >= MinLatC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      tag_q      <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            tag_q      <= in_tag_i;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (in_op_b_i != '0) begin
              op_a_q  <= in_op_a_i;
              op_b_q  <= in_op_b_i;
              start_q <= 1'b1;
              state_q <= StStart;
            end else begin
              // Divide-by-zero never reaches the divider.
              result_q <= '0;
              exc_q    <= 1'b1;
              valid_q  <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (rdy_honoured) begin
            result_q <= div_result_i;
            exc_q    <= div_exception_i;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end else if (cnt_q == TimeoutLastC) begin
            result_q <= '0;
            exc_q    <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign div_op_a_o      = op_a_q;
  assign div_op_b_o      = op_b_q;
  assign div_start_o     = start_q;
  assign out_valid_o     = valid_q;
  assign out_result_o    = result_q;
  assign out_exception_o = exc_q;
  assign out_tag_o       = tag_q;
  assign busy_o          = busy_q;

  a_start_one_cycle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    div_start_o |=> !div_start_o);
  a_ready_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_ready_o != busy_o);
  a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> out_valid_o);

endmodule
